float_unpack: RTL and testbench



---
 rtl/float_unpack_pkg.sv | 17 +
 rtl/float_field_decode.sv | 14 +
 rtl/float_unpack.sv | 135 +++++++++++++
 tb/tb_float_unpack.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/float_unpack_pkg.sv
// Shared constants for the FALU operand front end: opcodes, exponent bias and
// unpack sequencer states.
package float_unpack_pkg;

    localparam logic [4:0] FADDOP = 5'd1;
    localparam logic [4:0] FSUBOP = 5'd2;
    localparam logic [4:0] FMULOP = 5'd3;

    localparam int FP_BIAS = 127;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        DONE  = 2'd2
    } unpack_state_t;

endpackage

// File: rtl/float_field_decode.sv
// Splits an IEEE single into sign, exponent and {hidden, fraction}.
// A zero exponent is treated as zero: hidden bit and fraction are both cleared.
module float_field_decode (
    input  logic [31:0] value,
    output logic        sign,
    output logic [7:0]  exponent,
    output logic [23:0] frac
);

    assign sign     = value[31];
    assign exponent = value[30:23];
    assign frac     = (value[30:23] == 8'd0) ? 24'd0 : {1'b1, value[22:0]};

endmodule

// File: rtl/float_unpack.sv
// FALU operand front end: orders and aligns add/sub fractions one bit per cycle,
// passes mul fractions through with the biased exponent sum.
module float_unpack
    import float_unpack_pkg::*;
#(
    parameter int ALIGN_MAX = 25,
    parameter int BIAS      = FP_BIAS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic [4:0]  FALUop,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] fracMAX,
    output logic [23:0] fracMIN,
    output logic [7:0]  expMAX,
    output logic [7:0]  expSUM,
    output logic        swap,
    output logic        signMAX,
    output logic        signMIN,
    output logic        sign,
    output logic [4:0]  opOut
);

    localparam logic [7:0] ALIGN_LIM = 8'(ALIGN_MAX);

    unpack_state_t state;
    logic [4:0]    cnt;

    logic        sign_a, sign_b;
    logic [7:0]  exp_a, exp_b;
    logic [23:0] frac_a, frac_b;

    float_field_decode u_dec_a (.value(opA), .sign(sign_a), .exponent(exp_a), .frac(frac_a));
    float_field_decode u_dec_b (.value(opB), .sign(sign_b), .exponent(exp_b), .frac(frac_b));

    logic        is_sub, is_addsub, is_mul;
    logic        sign_b_eff, swap_c;
    logic        sign_hi, sign_lo;
    logic [7:0]  exp_hi, exp_lo, diff;
    logic [23:0] frac_hi, frac_lo;
    logic [8:0]  exp_sum_w;

    assign is_sub     = (FALUop == FSUBOP);
    assign is_addsub  = (FALUop == FADDOP) || is_sub;
    assign is_mul     = (FALUop == FMULOP);
    assign sign_b_eff = sign_b ^ is_sub;
    // Ties keep A as the larger operand.
    assign swap_c     = {exp_b, frac_b} > {exp_a, frac_a};
    assign sign_hi    = swap_c ? sign_b_eff : sign_a;
    assign sign_lo    = swap_c ? sign_a : sign_b_eff;
    assign exp_hi     = swap_c ? exp_b : exp_a;
    assign exp_lo     = swap_c ? exp_a : exp_b;
    assign frac_hi    = swap_c ? frac_b : frac_a;
    assign frac_lo    = swap_c ? frac_a : frac_b;
    assign diff       = exp_hi - exp_lo;
    assign exp_sum_w  = {1'b0, exp_a} + {1'b0, exp_b} - 9'(BIAS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            fracMAX   <= 24'd0;
            fracMIN   <= 24'd0;
            expMAX    <= 8'd0;
            expSUM    <= 8'd0;
            swap      <= 1'b0;
            signMAX   <= 1'b0;
            signMIN   <= 1'b0;
            sign      <= 1'b0;
            opOut     <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_ready && in_valid) begin
                        in_ready <= 1'b0;
                        opOut    <= FALUop;
                        sign     <= sign_a ^ sign_b_eff;
                        cnt      <= diff[4:0];
                        if (is_addsub) begin
                            swap    <= swap_c;
                            fracMAX <= frac_hi;
                            fracMIN <= (diff >= ALIGN_LIM) ? 24'd0 : frac_lo;
                            expMAX  <= exp_hi;
                            expSUM  <= exp_sum_w[7:0];
                            signMAX <= sign_hi;
                            signMIN <= sign_lo;
                            if (diff != 8'd0 && diff < ALIGN_LIM) begin
                                state <= ALIGN;
                            end else begin
                                state     <= DONE;
                                out_valid <= 1'b1;
                            end
                        end else begin
                            swap      <= 1'b0;
                            fracMAX   <= is_mul ? frac_a : 24'd0;
                            fracMIN   <= is_mul ? frac_b : 24'd0;
                            expMAX    <= is_mul ? exp_a : 8'd0;
                            expSUM    <= is_mul ? exp_sum_w[7:0] : 8'd0;
                            signMAX   <= sign_a;
                            signMIN   <= sign_b_eff;
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ALIGN: begin
                    fracMIN <= fracMIN >> 1;
                    cnt     <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_unpack.sv
// Randomized and directed checks of float_unpack against a value-level model
// of operand ordering, alignment and latency.
module tb_float_unpack;
    import float_unpack_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] opA = 32'd0;
    logic [31:0] opB = 32'd0;
    logic [4:0]  FALUop = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] fracMAX, fracMIN;
    logic [7:0]  expMAX, expSUM;
    logic        swap, signMAX, signMIN, sign;
    logic [4:0]  opOut;

    int checks = 0;
    int fails  = 0;

    float_unpack dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opA(opA), .opB(opB), .FALUop(FALUop), .out_valid(out_valid),
        .out_ready(out_ready), .fracMAX(fracMAX), .fracMIN(fracMIN),
        .expMAX(expMAX), .expSUM(expSUM), .swap(swap), .signMAX(signMAX),
        .signMIN(signMIN), .sign(sign), .opOut(opOut)
    );

    always #5 clk = ~clk;

    function automatic logic [72:0] observed();
        return {fracMAX, fracMIN, expMAX, expSUM, swap, signMAX, signMIN, sign, opOut};
    endfunction

    // Value-level model: magnitudes compared as numbers, alignment as a plain shift.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] op, output logic [72:0] fields,
                                  output int lat);
        int ea, eb, ehi, elo, d, s;
        logic [23:0] fa, fb, fhi, flo, fmin;
        logic sa, sb, sw, shi, slo;
        logic [7:0] esum;
        logic [30:0] mag_a, mag_b;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = (ea == 0) ? 24'd0 : {1'b1, a[22:0]};
        fb = (eb == 0) ? 24'd0 : {1'b1, b[22:0]};
        sa = a[31];
        sb = b[31] ^ (op == FSUBOP);
        s = ea + eb - 127;
        esum = s[7:0];
        lat = 1;
        if (op == FADDOP || op == FSUBOP) begin
            mag_a = (ea == 0) ? 31'd0 : a[30:0];
            mag_b = (eb == 0) ? 31'd0 : b[30:0];
            sw  = mag_b > mag_a;
            ehi = sw ? eb : ea;
            elo = sw ? ea : eb;
            fhi = sw ? fb : fa;
            flo = sw ? fa : fb;
            shi = sw ? sb : sa;
            slo = sw ? sa : sb;
            d = ehi - elo;
            fmin = (d >= 25) ? 24'd0 : (flo >> d);
            if (d > 0 && d < 25) lat = d + 1;
            fields = {fhi, fmin, 8'(ehi), esum, sw, shi, slo, sa ^ sb, op};
        end else if (op == FMULOP) begin
            fields = {fa, fb, 8'(ea), esum, 1'b0, sa, sb, sa ^ sb, op};
        end else begin
            fields = {24'd0, 24'd0, 8'd0, 8'd0, 1'b0, sa, sb, sa ^ sb, op};
        end
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                          input int hold, input bit keep_valid, input string name);
        logic [72:0] want, got;
        int lat, n;
        model(a, b, op, want, lat);
        n = 0;
        while (!in_ready && n < 60) begin @(posedge clk); #1; n++; end
        opA = a; opB = b; FALUop = op; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = keep_valid;
        opA = $urandom; opB = $urandom; FALUop = 5'($urandom_range(0, 31));
        checks++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL %s in_ready_after_accept: got %b want 0", name, in_ready);
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        checks++;
        if (n + 1 !== lat) begin
            fails++; $display("FAIL %s latency: got %0d want %0d", name, n + 1, lat);
        end
        got = observed();
        checks++;
        if (got !== want) begin
            fails++; $display("FAIL %s fields: got %h want %h", name, got, want);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checks++;
            if (observed() !== want || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL %s hold%0d: got %h v%b r%b want %h v1 r0",
                         name, i, observed(), out_valid, in_ready, want);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s handshake: got v%b r%b want v0 r1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || observed() !== 73'd0) begin
            fails++; $display("FAIL reset_outputs: got v%b %h want v0 0", out_valid, observed());
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_release: got r%b v%b want r1 v0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        run_op(32'h3F800000, 32'h3F800000, FADDOP, 0, 1'b0, "add_equal");
        run_op(32'h3F800000, 32'h3E800000, FADDOP, 0, 1'b0, "add_diff2");
        run_op(32'h3E800000, 32'h40000000, FSUBOP, 0, 1'b0, "sub_b_larger");
        run_op(32'h40000000, 32'hC0400000, FMULOP, 0, 1'b0, "mul");
        run_op(32'h3F800000, 32'h30800000, FADDOP, 0, 1'b0, "add_diff_ge25");
        run_op(32'h3F800000, 32'h33800000, FADDOP, 0, 1'b0, "add_diff24");
        run_op(32'h00000000, 32'h3F800000, FADDOP, 0, 1'b0, "zero_operand");
        run_op(32'h3F812345, 32'hBF812345, FSUBOP, 0, 1'b0, "tie");
        run_op(32'h12345678, 32'h9ABCDEF0, 5'd7, 0, 1'b0, "other_op");
    endtask

    task automatic test_backpressure();
        run_op(32'h41200000, 32'h3FC00000, FSUBOP, 5, 1'b0, "backpressure");
        run_op(32'hC0A00000, 32'h40A00001, FADDOP, 3, 1'b1, "busy_in_valid");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [4:0] op;
        int ea, eb;
        for (int i = 0; i < 120; i++) begin
            ea = $urandom_range(0, 255);
            case ($urandom_range(0, 3))
                0: eb = $urandom_range(0, 255);
                1: eb = ea;
                default: eb = ea + $urandom_range(0, 30) - 15;
            endcase
            if (eb < 0) eb = 0;
            if (eb > 255) eb = 255;
            a = {1'($urandom), 8'(ea), 23'($urandom)};
            b = {1'($urandom), 8'(eb), 23'($urandom)};
            case ($urandom_range(0, 6))
                0, 1: op = FADDOP;
                2, 3: op = FSUBOP;
                4, 5: op = FMULOP;
                default: op = 5'($urandom_range(4, 31));
            endcase
            run_op(a, b, op, $urandom_range(0, 2), 1'($urandom), "random");
        end
    endtask

    task automatic test_reset_mid_align();
        bit seen;
        int n;
        n = 0;
        while (!in_ready && n < 60) begin @(posedge clk); #1; n++; end
        opA = 32'h3F800000; opB = 32'h3A800000; FALUop = FADDOP; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || observed() !== 73'd0) begin
            fails++;
            $display("FAIL reset_mid_align: got v%b r%b %h want v0 r0 0", out_valid, in_ready, observed());
        end
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            fails++; $display("FAIL discarded_op: got out_valid seen %b want 0", seen);
        end
        run_op(32'h3F800000, 32'h3A800000, FADDOP, 1, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid_align();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
